// File: rtl/round_sgf_pipe.sv
// Two-stage rounding pipeline: S1 decides the round increment, S2 applies it.
// Carry-out renormalises the significand; exponent overflow yields infinity.
module round_sgf_pipe #(
    parameter int SW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [SW-1:0] Sgf_i,
    input  logic [EW-1:0] Exp_i,
    input  logic          Sign_Result_i,
    input  logic [1:0]    Data_i,
    input  logic [1:0]    Round_type,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [SW-1:0] Sgf_o,
    output logic [EW-1:0] Exp_o,
    output logic          Sign_o,
    output logic          Inexact_o,
    output logic          Overflow_o
);

    localparam logic [EW-1:0] EXP_MAX = '1;

    logic          s1_valid_q;
    logic [SW-1:0] s1_sgf_q;
    logic [EW-1:0] s1_exp_q;
    logic          s1_sign_q;
    logic          s1_inc_q;
    logic          s1_inexact_q;
    logic          s1_special_q;

    logic          s1_inc_d;
    logic          s1_inexact_d;
    logic          s1_special_d;

    logic          s2_valid_q;
    logic [SW-1:0] s2_sgf_q;
    logic [EW-1:0] s2_exp_q;
    logic          s2_sign_q;
    logic          s2_inexact_q;
    logic          s2_overflow_q;

    logic [SW-1:0] s2_sgf_d;
    logic [EW-1:0] s2_exp_d;
    logic          s2_overflow_d;

    logic          adv2;
    logic          adv1;
    logic          grd;
    logic          stk;
    logic          lsb;
    logic          carry;
    logic [SW-1:0] sum;
    logic [EW-1:0] exp_inc;

    // Stall propagates backwards combinationally; no skid buffer
    always_comb begin
        adv2    = ~s2_valid_q | ready_i;
        adv1    = ~s1_valid_q | adv2;
        ready_o = adv1;
    end

    // Round decision from mode, sign, guard/sticky and LSB
    always_comb begin
        grd          = Data_i[1];
        stk          = Data_i[0];
        lsb          = Sgf_i[0];
        s1_special_d = (Exp_i == EXP_MAX);
        s1_inc_d     = 1'b0;
        unique case (Round_type)
            2'b00: s1_inc_d = 1'b0;
            2'b01: s1_inc_d = Sign_Result_i & (grd | stk);
            2'b10: s1_inc_d = ~Sign_Result_i & (grd | stk);
            2'b11: s1_inc_d = grd & (stk | lsb);
            default: s1_inc_d = 1'b0;
        endcase
        s1_inexact_d = (grd | stk) & ~s1_special_d;
        if (s1_special_d) begin
            s1_inc_d = 1'b0;
        end
    end

    // S1 register: capture on input handshake, drain when S2 takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_sgf_q     <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_inc_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
            s1_special_q <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_sgf_q     <= Sgf_i;
                s1_exp_q     <= Exp_i;
                s1_sign_q    <= Sign_Result_i;
                s1_inc_q     <= s1_inc_d;
                s1_inexact_q <= s1_inexact_d;
                s1_special_q <= s1_special_d;
            end
        end
    end

    // Increment, renormalise on carry, saturate to infinity on overflow
    always_comb begin
        {carry, sum}  = {1'b0, s1_sgf_q} + {{SW{1'b0}}, s1_inc_q};
        exp_inc       = s1_exp_q + {{(EW-1){1'b0}}, 1'b1};
        s2_sgf_d      = sum;
        s2_exp_d      = s1_exp_q;
        s2_overflow_d = 1'b0;
        if (carry && !s1_special_q) begin
            if (exp_inc == EXP_MAX) begin
                s2_sgf_d      = '0;
                s2_exp_d      = EXP_MAX;
                s2_overflow_d = 1'b1;
            end else begin
                s2_sgf_d = {1'b1, sum[SW-1:1]};
                s2_exp_d = exp_inc;
            end
        end
    end

    // S2 output register: loads only from a valid S1, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q    <= 1'b0;
            s2_sgf_q      <= '0;
            s2_exp_q      <= '0;
            s2_sign_q     <= 1'b0;
            s2_inexact_q  <= 1'b0;
            s2_overflow_q <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sgf_q      <= s2_sgf_d;
                s2_exp_q      <= s2_exp_d;
                s2_sign_q     <= s1_sign_q;
                s2_inexact_q  <= s1_inexact_q;
                s2_overflow_q <= s2_overflow_d;
            end
        end
    end

    // Drive outputs straight from the S2 register
    always_comb begin
        valid_o    = s2_valid_q;
        Sgf_o      = s2_sgf_q;
        Exp_o      = s2_exp_q;
        Sign_o     = s2_sign_q;
        Inexact_o  = s2_inexact_q;
        Overflow_o = s2_overflow_q;
    end

endmodule

// File: tb/tb_round_sgf_pipe.sv
// Directed bench for round_sgf_pipe: vector table, backpressure, mid-stream reset.
// Inputs driven on negedge; outputs sampled 1ns after posedge or negedge.
module tb_round_sgf_pipe;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [23:0] Sgf_i;
    logic [7:0]  Exp_i;
    logic        Sign_Result_i;
    logic [1:0]  Data_i;
    logic [1:0]  Round_type;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] Sgf_o;
    logic [7:0]  Exp_o;
    logic        Sign_o;
    logic        Inexact_o;
    logic        Overflow_o;

    int checks = 0;
    int errors = 0;

    round_sgf_pipe #(.SW(24), .EW(8)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o),
        .Sgf_i(Sgf_i), .Exp_i(Exp_i),
        .Sign_Result_i(Sign_Result_i),
        .Data_i(Data_i), .Round_type(Round_type),
        .valid_o(valid_o), .ready_i(ready_i),
        .Sgf_o(Sgf_o), .Exp_o(Exp_o), .Sign_o(Sign_o),
        .Inexact_o(Inexact_o), .Overflow_o(Overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [23:0] sgf;
        logic [7:0]  exp;
        logic        sign;
        logic [1:0]  data;
        logic [1:0]  mode;
        logic [23:0] e_sgf;
        logic [7:0]  e_exp;
        logic        e_inex;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [23:0] bp_in  [6];
    logic [23:0] bp_exp [6];
    logic [1:0]  bp_mode[6];
    logic [23:0] held_sgf;
    int sent;
    int rcv;

    initial begin
        vecs[0]  = '{"m00",       24'h800001, 8'h80, 1'b0, 2'b01, 2'b00, 24'h800001, 8'h80, 1'b1, 1'b0};
        vecs[1]  = '{"m10_pos",   24'h800001, 8'h80, 1'b0, 2'b01, 2'b10, 24'h800002, 8'h80, 1'b1, 1'b0};
        vecs[2]  = '{"m01_pos",   24'h800001, 8'h80, 1'b0, 2'b01, 2'b01, 24'h800001, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{"m01_neg",   24'h800001, 8'h80, 1'b1, 2'b01, 2'b01, 24'h800002, 8'h80, 1'b1, 1'b0};
        vecs[4]  = '{"rne_tie_ev",24'h800000, 8'h80, 1'b0, 2'b10, 2'b11, 24'h800000, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{"rne_tie_od",24'h800001, 8'h80, 1'b0, 2'b10, 2'b11, 24'h800002, 8'h80, 1'b1, 1'b0};
        vecs[6]  = '{"rne_above", 24'h800000, 8'h80, 1'b0, 2'b11, 2'b11, 24'h800001, 8'h80, 1'b1, 1'b0};
        vecs[7]  = '{"carry",     24'hFFFFFF, 8'h80, 1'b0, 2'b01, 2'b10, 24'h800000, 8'h81, 1'b1, 1'b0};
        vecs[8]  = '{"overflow",  24'hFFFFFF, 8'hFE, 1'b0, 2'b01, 2'b10, 24'h000000, 8'hFF, 1'b1, 1'b1};
        vecs[9]  = '{"special",   24'hC00000, 8'hFF, 1'b0, 2'b11, 2'b11, 24'hC00000, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{"exact",     24'h800001, 8'h80, 1'b1, 2'b00, 2'b11, 24'h800001, 8'h80, 1'b0, 1'b0};
        vecs[11] = '{"rne_below", 24'h800001, 8'h80, 1'b1, 2'b01, 2'b11, 24'h800001, 8'h80, 1'b1, 1'b0};

        bp_in[0] = 24'h800010; bp_mode[0] = 2'b10; bp_exp[0] = 24'h800011;
        bp_in[1] = 24'h800012; bp_mode[1] = 2'b00; bp_exp[1] = 24'h800012;
        bp_in[2] = 24'h800014; bp_mode[2] = 2'b10; bp_exp[2] = 24'h800015;
        bp_in[3] = 24'h800016; bp_mode[3] = 2'b00; bp_exp[3] = 24'h800016;
        bp_in[4] = 24'h800018; bp_mode[4] = 2'b10; bp_exp[4] = 24'h800019;
        bp_in[5] = 24'h80001A; bp_mode[5] = 2'b00; bp_exp[5] = 24'h80001A;

        rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        Sgf_i = '0;
        Exp_i = '0;
        Sign_Result_i = 1'b0;
        Data_i = '0;
        Round_type = '0;

        #1;
        chk("rst_valid_o", 32'(valid_o), 32'h0);
        chk("rst_sgf_o", 32'(Sgf_o), 32'h0);
        chk("rst_exp_o", 32'(Exp_o), 32'h0);
        chk("rst_flags", {29'h0, Sign_o, Inexact_o, Overflow_o}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_ready_o", 32'(ready_o), 32'h1);

        // Directed table: one transaction at a time
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid_i = 1'b1;
            Sgf_i = vecs[i].sgf;
            Exp_i = vecs[i].exp;
            Sign_Result_i = vecs[i].sign;
            Data_i = vecs[i].data;
            Round_type = vecs[i].mode;
            #1;
            chk({vecs[i].name, "_ready"}, 32'(ready_o), 32'h1);
            @(posedge clk);
            @(negedge clk);
            valid_i = 1'b0;
            #1;
            chk({vecs[i].name, "_lat1"}, 32'(valid_o), 32'h0);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_valid"}, 32'(valid_o), 32'h1);
            chk({vecs[i].name, "_sgf"}, 32'(Sgf_o), 32'(vecs[i].e_sgf));
            chk({vecs[i].name, "_exp"}, 32'(Exp_o), 32'(vecs[i].e_exp));
            chk({vecs[i].name, "_sign"}, 32'(Sign_o), 32'(vecs[i].sign));
            chk({vecs[i].name, "_inex"}, 32'(Inexact_o), 32'(vecs[i].e_inex));
            chk({vecs[i].name, "_ovf"}, 32'(Overflow_o), 32'(vecs[i].e_ovf));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_bubble"}, 32'(valid_o), 32'h0);
            chk({vecs[i].name, "_hold"}, 32'(Sgf_o), 32'(vecs[i].e_sgf));
        end

        // Backpressure: 6 back-to-back, ready_i low for cycles 3..5
        sent = 0;
        rcv = 0;
        held_sgf = '0;
        Exp_i = 8'h80;
        Data_i = 2'b01;
        Sign_Result_i = 1'b0;
        for (int c = 0; c < 30 && rcv < 6; c++) begin
            @(negedge clk);
            ready_i = !(c >= 3 && c <= 5);
            if (sent < 6) begin
                valid_i = 1'b1;
                Sgf_i = bp_in[sent];
                Round_type = bp_mode[sent];
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 5) begin
                chk("bp_ready_low", 32'(ready_o), 32'h0);
                chk("bp_stall_valid", 32'(valid_o), 32'h1);
            end
            if (c == 3) held_sgf = Sgf_o;
            if (c >= 4 && c <= 5) chk("bp_stable", 32'(Sgf_o), 32'(held_sgf));
            if (c >= 6 && rcv < 6) chk("bp_throughput", 32'(valid_o), 32'h1);
            if (valid_o && ready_i) begin
                chk("bp_order", 32'(Sgf_o), 32'(bp_exp[rcv]));
                rcv++;
            end
            if (valid_i && ready_o) sent++;
            @(posedge clk);
        end
        chk("bp_count", 32'(rcv), 32'h6);
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk);

        // Reset with two transactions in flight
        @(negedge clk);
        valid_i = 1'b1;
        Sgf_i = 24'h812345;
        Round_type = 2'b10;
        @(posedge clk);
        @(negedge clk);
        Sgf_i = 24'h823456;
        @(posedge clk);
        #1;
        chk("mid_valid_before", 32'(valid_o), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_o), 32'h0);
        chk("mid_rst_sgf", 32'(Sgf_o), 32'h0);
        @(negedge clk);
        valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_ready_after", 32'(ready_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
            chk("mid_no_stale", 32'(valid_o), 32'h0);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_sgf_pipe.md
Name: round_sgf_pipe

Overview:
- Parametrised, pipelined successor to the add/subtract datapath's combinational round-decision logic.
- Takes a normalised significand, its guard/sticky bits, exponent, sign and rounding mode.
- Decides whether to increment, applies the increment, and renormalises on carry-out. Exponent overflow produces infinity.
- Adds round-to-nearest-even and valid/ready flow control. Sits between the normaliser and the final result packer.

Parameters:
- SW, 24, significand width including hidden bit (MSB).
- EW, 8, exponent width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  input transaction valid.
- ready_o  output  1  block can accept an input this cycle.
- Sgf_i  input  SW  normalised significand, hidden bit at MSB.
- Exp_i  input  EW  biased exponent.
- Sign_Result_i  input  1  sign of result.
- Data_i  input  2  {guard, sticky}; sticky is OR of all bits below guard.
- Round_type  input  2  00 toward zero, 01 toward -inf, 10 toward +inf, 11 nearest-even.
- valid_o  output  1  output transaction valid.
- ready_i  input  1  downstream accepts output.
- Sgf_o  output  SW  rounded significand.
- Exp_o  output  EW  adjusted exponent.
- Sign_o  output  1  sign passthrough.
- Inexact_o  output  1  Data_i != 00 on a finite input.
- Overflow_o  output  1  rounding carried the exponent to all-ones.

Behaviour:
- Reset (async, rst=1): both stage valids = 0. valid_o=0, Sgf_o=0, Exp_o=0, Sign_o=0, Inexact_o=0, Overflow_o=0. ready_o=1 from the first cycle after reset release.
- Reset mid-operation: in-flight transactions are discarded, not completed.
- Pipeline: two register stages (S1 decision, S2 increment/renormalise). Latency is 2 cycles from input handshake to valid_o with ready_i held high. Throughput is 1 per cycle.
- Handshake: an input transfer occurs when valid_i & ready_o.
  - S2 advances when ~S2.valid | ready_i.
  - S1 advances when ~S1.valid | S2 advance.
  - ready_o = S1 advance (combinational from ready_i; no skid buffer).
  - While valid_o & ~ready_i, all outputs hold stable. Inputs presented with ready_o=0 are not captured.
- S1 round flag (inc), with G=Data_i[1], S=Data_i[0], L=Sgf_i[0]:
  - mode 00: inc=0.
  - mode 01: inc = Sign & (G|S).
  - mode 10: inc = ~Sign & (G|S).
  - mode 11: inc = G & (S|L). Ties go to even.
  - S1 registers Sgf, Exp, Sign, inc, inexact=(G|S), special=(Exp_i==all-ones).
- Special inputs (Exp_i all-ones, inf/NaN): inc forced 0, inexact forced 0. Sgf/Exp pass through unchanged; Overflow_o=0.
- S2 arithmetic: {c, sum} = Sgf + inc, computed SW+1 bits wide.
  - c=0: Sgf_o=sum, Exp_o=Exp.
  - c=1: Sgf_o={1'b1, sum[SW-1:1]} (= 1000..0), Exp_o=Exp+1.
  - If c=1 and Exp+1 == all-ones: Overflow_o=1, Exp_o=all-ones, Sgf_o=0 (infinity); Inexact_o remains 1.
- Sign_o always equals the captured sign. Round_type is sampled per transaction, so a mode change between back-to-back transfers affects only later transactions.
- Bubbles: S2 loads only when S1.valid. Output registers retain their last value when valid_o=0.

Test Plan:
- Reset mid-stream: two transactions in flight, assert rst -> valid_o=0 immediately; ready_o=1 the cycle after rst deasserts; no stale output ever appears.
- Directed modes, Sgf_i=24'h800001, Exp_i=8'h80, Data_i=2'b01:
  - mode 00 -> Sgf_o=24'h800001, Inexact_o=1.
  - mode 10 sign 0 -> 24'h800002.
  - mode 01 sign 0 -> 24'h800001.
  - mode 01 sign 1 -> 24'h800002.
- Nearest-even ties, mode 11, Data_i=2'b10:
  - Sgf_i=24'h800000 -> 24'h800000.
  - Sgf_i=24'h800001 -> 24'h800002.
  - Data_i=2'b11 with Sgf_i=24'h800000 -> 24'h800001.
- Carry renormalise and overflow, mode 10 sign 0, Data_i=2'b01, Sgf_i=24'hFFFFFF:
  - Exp_i=8'h80 -> Sgf_o=24'h800000, Exp_o=8'h81, Overflow_o=0.
  - Exp_i=8'hFE -> Exp_o=8'hFF, Sgf_o=0, Overflow_o=1.
- Special passthrough: Exp_i=8'hFF, Sgf_i=24'hC00000, Data_i=2'b11, mode 11 -> outputs unchanged, Inexact_o=0, Overflow_o=0.
- Backpressure: stream 6 back-to-back transactions, ready_i low for 3 cycles mid-stream -> ready_o drops within the same cycle once both stages are full; outputs stable while stalled; all 6 results emerge in order, none lost or duplicated; 1/cycle throughput once ready_i returns high.
